// File: rtl/lcd8080_pkg.sv
// Shared definitions for the 8080-style LCD bus responder.
//   bus_state_e : bus FSM states (idle, write strobe active, read strobe active)
//   entry_t     : captured bus word {rs, data} at the default bus width
//   ENTRY_W     : width of entry_t
package lcd8080_pkg;

  localparam int unsigned LCD_DW  = 16;
  localparam int unsigned ENTRY_W = LCD_DW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACT = 2'd1,
    ST_RD_ACT = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic              rs;
    logic [LCD_DW-1:0] data;
  } entry_t;

endpackage

// File: rtl/lcd8080_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : synchronous empty, overrides push/pop
//   wr_en, wr_data     : push (ignored when full unless popping same cycle)
//   rd_en              : pop head (ignored when empty)
//   rd_data            : current head word
//   full, empty, level : occupancy status
module lcd8080_fifo
  import lcd8080_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem [DEPTH];
  logic         do_wr, do_rd;

  always_comb begin
    level = wr_ptr_q - rd_ptr_q;
    empty = (wr_ptr_q == rd_ptr_q);
    // Extra wrap bit distinguishes full from empty when the index bits match.
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd = rd_en && !empty && !flush;
    do_wr = wr_en && (!full || do_rd) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/lcd8080_rx.sv
// Panel-side responder for an 8080-style parallel LCD bus.
//   PCLK, PRESETn            : system clock, asynchronous active-low reset
//   LCD_CS/RS/WR/RD/RST      : asynchronous bus strobes (CS/WR/RD/RST active-low)
//   LCD_DATA_I               : bus data from master
//   LCD_DATA_O, LCD_DATA_OE  : readback data and pad enable during RD cycles
//   rd_data, rd_done         : host readback word, end-of-read pulse
//   out_valid/ready/rs/data  : captured-word stream (FIFO head)
//   level                    : FIFO occupancy
//   ovf, perr, clr_err       : sticky overflow / protocol error, clear
module lcd8080_rx
  import lcd8080_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   LCD_CS,
  input  logic                   LCD_RS,
  input  logic                   LCD_WR,
  input  logic                   LCD_RD,
  input  logic                   LCD_RST,
  input  logic [DW-1:0]          LCD_DATA_I,
  output logic [DW-1:0]          LCD_DATA_O,
  output logic                   LCD_DATA_OE,
  input  logic [DW-1:0]          rd_data,
  output logic                   rd_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_rs,
  output logic [DW-1:0]          out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   perr,
  input  logic                   clr_err
);

  logic cs_s1_q, cs_s2_q, rs_s1_q, rs_s2_q, rst_s1_q, rst_s2_q;
  logic wr_s1_q, wr_s2_q, wr_s3_q, rd_s1_q, rd_s2_q, rd_s3_q;
  logic [DW-1:0] data_s1_q, data_s2_q;

  bus_state_e    state_q, state_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          rd_done_q, rd_done_d;
  logic          ovf_q, ovf_d, perr_q, perr_d;

  logic          wr_rise, rd_rise, push, perr_set, pop, fifo_wr;
  logic          fifo_full, fifo_empty;
  logic [DW:0]   head;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cs_s1_q   <= 1'b1;  cs_s2_q  <= 1'b1;
      rs_s1_q   <= 1'b1;  rs_s2_q  <= 1'b1;
      rst_s1_q  <= 1'b1;  rst_s2_q <= 1'b1;
      wr_s1_q   <= 1'b1;  wr_s2_q  <= 1'b1;  wr_s3_q <= 1'b1;
      rd_s1_q   <= 1'b1;  rd_s2_q  <= 1'b1;  rd_s3_q <= 1'b1;
      data_s1_q <= '0;    data_s2_q <= '0;
    end else begin
      cs_s1_q   <= LCD_CS;     cs_s2_q   <= cs_s1_q;
      rs_s1_q   <= LCD_RS;     rs_s2_q   <= rs_s1_q;
      rst_s1_q  <= LCD_RST;    rst_s2_q  <= rst_s1_q;
      wr_s1_q   <= LCD_WR;     wr_s2_q   <= wr_s1_q;  wr_s3_q <= wr_s2_q;
      rd_s1_q   <= LCD_RD;     rd_s2_q   <= rd_s1_q;  rd_s3_q <= rd_s2_q;
      data_s1_q <= LCD_DATA_I; data_s2_q <= data_s1_q;
    end
  end

  assign wr_rise = wr_s2_q & ~wr_s3_q;
  assign rd_rise = rd_s2_q & ~rd_s3_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rd_done_d = 1'b0;
    push      = 1'b0;
    perr_set  = 1'b0;
    if (!rst_s2_q) begin
      state_d = ST_IDLE;
    end else if (!cs_s2_q && !wr_s2_q && !rd_s2_q) begin
      perr_set = 1'b1;
      state_d  = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cs_s2_q && !wr_s2_q && rd_s2_q) begin
            state_d = ST_WR_ACT;
          end else if (!cs_s2_q && !rd_s2_q && wr_s2_q) begin
            state_d = ST_RD_ACT;
            hold_d  = rd_data;
          end
        end
        ST_WR_ACT: begin
          // WR rise is pushed even when CS rises alongside, as long as the
          // synchronized CS is still low this cycle.
          if (wr_rise) begin
            push    = !cs_s2_q;
            state_d = ST_IDLE;
          end else if (cs_s2_q) begin
            state_d = ST_IDLE;
          end
        end
        ST_RD_ACT: begin
          if (rd_rise) begin
            rd_done_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (cs_s2_q) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pop     = out_valid & out_ready;
  assign fifo_wr = push & (~fifo_full | pop);

  always_comb begin
    ovf_d  = ovf_q  | (push & fifo_full & ~pop);
    perr_d = perr_q | perr_set;
    if (clr_err) begin
      ovf_d  = 1'b0;
      perr_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      rd_done_q <= 1'b0;
      ovf_q     <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rd_done_q <= rd_done_d;
      ovf_q     <= ovf_d;
      perr_q    <= perr_d;
    end
  end

  lcd8080_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 1)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .flush   (~rst_s2_q),
    .wr_en   (fifo_wr),
    .wr_data ({rs_s2_q, data_s2_q}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Head is masked while empty so the stream outputs read zero out of reset.
  assign out_valid   = ~fifo_empty;
  assign out_rs      = out_valid & head[DW];
  assign out_data    = out_valid ? head[DW-1:0] : '0;
  assign LCD_DATA_OE = (state_q == ST_RD_ACT);
  assign LCD_DATA_O  = LCD_DATA_OE ? hold_q : '0;
  assign rd_done     = rd_done_q;
  assign ovf         = ovf_q;
  assign perr        = perr_q;

endmodule
